load_store_unit: RTL

- Byte-addressed load/store front end directly upstream of the word-addressed data memory.
- Accepts one request at a time from the execute stage and computes EA = base + offset.
- Checks alignment and range, then drives the data memory's word address and read/write strobes.
- Performs sign or zero extension on loads and read-modify-write for byte/halfword stores; returns a single-cycle response pulse.

---
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory.
// One request at a time: alignment/range check, sub-word extraction and read-modify-write.
module lsu_byte_lane (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       en,
  output logic [7:0] merged
);
  assign merged = en ? new_byte : old_byte;
endmodule

module load_store_unit #(
  parameter int size    = 32,
  parameter int MemSize = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [size-1:0] base,
  input  logic [size-1:0] offset,
  input  logic [size-1:0] store_data,
  output logic            resp_valid,
  output logic [size-1:0] resp_data,
  output logic            resp_fault,
  output logic [size-1:0] address,
  output logic            mem_read,
  output logic            mem_write,
  output logic [size-1:0] write_data,
  input  logic [size-1:0] read_data
);
  localparam int NUM_LANES = size / 8;
  localparam int LW        = $clog2(NUM_LANES);
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, WT, WR, RESP} state_t;

  typedef struct packed {
    logic [size-1:0] ea;
    logic            write;
    logic [1:0]      sz;
    logic            sgn;
    logic [15:0]     sdata;
  } req_t;

  state_t                     state, state_d;
  req_t                       r;
  logic [size-1:0]            ea_in, ea_cur;
  logic                       fault_in;
  logic [LW-1:0]              lane;
  logic [NUM_LANES-1:0][7:0]  merged;
  logic [7:0]                 byte_v;
  logic [15:0]                half_v;
  logic [size-1:0]            load_v;

  logic                       ready_d, rd_d, wr_d, rv_d, rf_d;
  logic [size-1:0]            addr_d, wdata_d, rdata_d;

  assign ea_in    = base + offset;
  assign fault_in = (req_size == SZ_X)
                  | ((req_size == SZ_H) && ea_in[0])
                  | ((req_size == SZ_W) && (ea_in[LW-1:0] != '0))
                  | ((ea_in >> LW) >= size'(MemSize));
  // The word-store path issues its write straight from IDLE, before r is loaded.
  assign ea_cur   = (state == IDLE) ? ea_in : r.ea;
  assign lane     = r.ea[LW-1:0];

  // Read-modify-write: each byte lane picks the stored byte or keeps the memory byte.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic       en;
    logic [7:0] nb;
    always_comb begin
      en = 1'b0;
      nb = r.sdata[7:0];
      if (r.sz == SZ_B) begin
        en = (lane == LW'(i));
      end else if (r.sz == SZ_H) begin
        en = (lane[LW-1:1] == (LW-1)'(i / 2));
        nb = r.sdata[8*(i%2) +: 8];
      end
    end
    lsu_byte_lane u_lane (
      .old_byte (read_data[8*i +: 8]),
      .new_byte (nb),
      .en       (en),
      .merged   (merged[i])
    );
  end

  assign byte_v = 8'(read_data >> {lane, 3'b000});
  assign half_v = 16'(read_data >> {lane[LW-1:1], 4'b0000});

  always_comb begin
    case (r.sz)
      SZ_B:    load_v = r.sgn ? {{(size-8){byte_v[7]}}, byte_v}  : {{(size-8){1'b0}}, byte_v};
      SZ_H:    load_v = r.sgn ? {{(size-16){half_v[15]}}, half_v} : {{(size-16){1'b0}}, half_v};
      default: load_v = read_data;
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (req_valid) begin
        if (fault_in)                          state_d = RESP;
        else if (req_write && req_size == SZ_W) state_d = WR;
        else                                   state_d = RD;
      end
      RD:      state_d = WT;
      WT:      state_d = r.write ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    ready_d = (state_d == IDLE);
    rd_d    = (state_d == RD);
    wr_d    = (state_d == WR);
    addr_d  = '0;
    if (state_d == RD || state_d == WT || state_d == WR) addr_d = ea_cur >> LW;
    wdata_d = '0;
    if (state_d == WR) wdata_d = (state == IDLE) ? store_data : merged;
    rv_d    = (state_d == RESP);
    rf_d    = (state_d == RESP) && (state == IDLE);
    rdata_d = (state == WT && state_d == RESP) ? load_v : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      r          <= '0;
      req_ready  <= 1'b1;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      address    <= '0;
      write_data <= '0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_data  <= '0;
    end else begin
      state      <= state_d;
      req_ready  <= ready_d;
      mem_read   <= rd_d;
      mem_write  <= wr_d;
      address    <= addr_d;
      write_data <= wdata_d;
      resp_valid <= rv_d;
      resp_fault <= rf_d;
      resp_data  <= rdata_d;
      if (req_valid && state == IDLE)
        r <= '{ea: ea_in, write: req_write, sz: req_size, sgn: req_signed, sdata: store_data[15:0]};
    end
  end
endmodule
